// File: rtl/ram_burst_ctrl_if.sv
// Handshake, command and RAM-side bundle for ram_burst_ctrl.
// The slave modport is the controller; the master modport is its environment.
interface ram_burst_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              wr_start;
    logic [ADDR_W-1:0] wr_base;
    logic              s_valid;
    logic [DATA_W-1:0] s_data;
    logic              s_last;
    logic              s_ready;
    logic              rd_start;
    logic [ADDR_W-1:0] rd_base;
    logic [ADDR_W:0]   rd_len;
    logic              m_valid;
    logic [DATA_W-1:0] m_data;
    logic              m_last;
    logic              m_ready;
    logic              busy;
    logic [ADDR_W:0]   wr_count;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;

    modport slave (
        input  wr_start, wr_base, s_valid, s_data, s_last,
        input  rd_start, rd_base, rd_len, m_ready, ram_dout,
        output s_ready, m_valid, m_data, m_last, busy, wr_count,
        output ram_we, ram_addr, ram_din
    );

    modport master (
        output wr_start, wr_base, s_valid, s_data, s_last,
        output rd_start, rd_base, rd_len, m_ready, ram_dout,
        input  s_ready, m_valid, m_data, m_last, busy, wr_count,
        input  ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/ram_burst_ctrl.sv
// Burst loader/replayer for a 1-cycle registered-read RAM; writes land in the handshake cycle,
// replay reaches m_valid two edges after rd_start is taken, and a 2-deep skid absorbs m_ready stalls.
module ram_burst_ctrl #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
) (
    input  logic            clk,
    input  logic            rst,
    ram_burst_ctrl_if.slave bus
);
    localparam int DEPTH = 2**ADDR_W;

    typedef enum logic [1:0] {IDLE, WRITE, READ} state_t;

    state_t            state;
    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W:0]   remaining;
    logic [ADDR_W:0]   wr_cnt;
    logic              s_rdy;
    logic              bsy;
    logic              inflight;
    logic              inflight_last;
    logic [1:0]        fcnt;
    logic [DATA_W-1:0] fdat0, fdat1;
    logic              flast0, flast1;

    logic              wr_hs;
    logic              pop;
    logic              push;
    logic              rd_issue;
    logic [1:0]        occupancy;

    // Occupancy counts the word leaving this cycle as gone, so reads stream back to back.
    always_comb begin
        wr_hs     = s_rdy & bus.s_valid & ~rst;
        pop       = (fcnt != 2'd0) & bus.m_ready;
        push      = inflight;
        occupancy = fcnt + {1'b0, inflight} - {1'b0, pop};
        rd_issue  = (state == READ) & (remaining != '0) & (occupancy < 2'd2) & ~rst;
    end

    assign bus.ram_we   = wr_hs;
    assign bus.ram_din  = bus.s_data;
    assign bus.ram_addr = (state == IDLE) ? '0 : ptr;
    assign bus.s_ready  = s_rdy;
    assign bus.busy     = bsy;
    assign bus.wr_count = wr_cnt;
    assign bus.m_valid  = (fcnt != 2'd0);
    assign bus.m_data   = fdat0;
    assign bus.m_last   = flast0 & (fcnt != 2'd0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ptr           <= '0;
            remaining     <= '0;
            wr_cnt        <= '0;
            s_rdy         <= 1'b0;
            bsy           <= 1'b0;
            inflight      <= 1'b0;
            inflight_last <= 1'b0;
            fcnt          <= 2'd0;
            fdat0         <= '0;
            fdat1         <= '0;
            flast0        <= 1'b0;
            flast1        <= 1'b0;
        end else begin
            inflight <= rd_issue;
            if (rd_issue) begin
                inflight_last <= (remaining == (ADDR_W+1)'(1));
            end

            case ({push, pop})
                2'b10: begin
                    if (fcnt == 2'd0) begin
                        fdat0  <= bus.ram_dout;
                        flast0 <= inflight_last;
                    end else begin
                        fdat1  <= bus.ram_dout;
                        flast1 <= inflight_last;
                    end
                    fcnt <= fcnt + 2'd1;
                end
                2'b01: begin
                    fdat0  <= fdat1;
                    flast0 <= flast1;
                    fcnt   <= fcnt - 2'd1;
                end
                2'b11: begin
                    if (fcnt == 2'd1) begin
                        fdat0  <= bus.ram_dout;
                        flast0 <= inflight_last;
                    end else begin
                        fdat0  <= fdat1;
                        flast0 <= flast1;
                        fdat1  <= bus.ram_dout;
                        flast1 <= inflight_last;
                    end
                end
                default: ;
            endcase

            case (state)
                IDLE: begin
                    if (bus.wr_start) begin
                        state  <= WRITE;
                        ptr    <= bus.wr_base;
                        wr_cnt <= '0;
                        s_rdy  <= 1'b1;
                        bsy    <= 1'b1;
                    end else if (bus.rd_start) begin
                        state     <= READ;
                        ptr       <= bus.rd_base;
                        remaining <= (bus.rd_len == '0) ? (ADDR_W+1)'(DEPTH) : bus.rd_len;
                        bsy       <= 1'b1;
                    end
                end
                WRITE: begin
                    if (wr_hs) begin
                        ptr    <= ptr + 1'b1;
                        wr_cnt <= wr_cnt + 1'b1;
                        if (bus.s_last || (wr_cnt == (ADDR_W+1)'(DEPTH-1))) begin
                            state <= IDLE;
                            s_rdy <= 1'b0;
                            bsy   <= 1'b0;
                        end
                    end
                end
                READ: begin
                    if (rd_issue) begin
                        ptr       <= ptr + 1'b1;
                        remaining <= remaining - 1'b1;
                    end
                    if (pop && flast0) begin
                        state <= IDLE;
                        bsy   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Randomised bench for ram_burst_ctrl: a behavioural RAM, a reference memory image and a
// replay scoreboard checked by an independent monitor.
module tb_ram_burst_ctrl;
    localparam int AW = 8;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    ram_burst_ctrl_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    ram_burst_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // 256x32 RAM with registered, read-first output.
    logic [DW-1:0] mem [256];
    always @(posedge clk) begin
        if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_din;
        bus.ram_dout <= mem[bus.ram_addr];
    end

    logic [DW-1:0] ref_mem [256];

    typedef struct packed {
        logic [DW-1:0] d;
        logic          l;
    } beat_t;
    beat_t exp_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Monitor: every accepted beat must be the next expected one; a stalled head must hold.
    logic          prev_stall = 1'b0;
    logic [DW-1:0] prev_d;
    logic          prev_l;
    always @(negedge clk) begin
        beat_t e;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_hold_valid", 64'(bus.m_valid), 64'(1));
                check("stall_hold_beat", {31'd0, bus.m_data, bus.m_last}, {31'd0, prev_d, prev_l});
            end
            if (bus.m_valid && bus.m_ready) begin
                check("beat_expected", 64'(exp_q.size() != 0), 64'(1));
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("beat_data", 64'(bus.m_data), 64'(e.d));
                    check("beat_last", 64'(bus.m_last), 64'(e.l));
                end
            end
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_d     = bus.m_data;
            prev_l     = bus.m_last;
        end
    end

    function automatic logic rdy_pat(input int mode, input int c);
        case (mode)
            0:       return 1'b1;
            1:       return (c % 4 == 0) || (c % 4 == 3);
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic wr_begin(input logic [7:0] base);
        @(posedge clk); #1;
        bus.wr_base  = base;
        bus.wr_start = 1'b1;
        @(posedge clk); #1;
        bus.wr_start = 1'b0;
    endtask

    task automatic wr_beats(input logic [7:0] base, input int n, input bit use_last,
                            input bit gaps, input logic [31:0] d0, input bit rnd);
        int          t;
        logic [31:0] d;
        for (int i = 0; i < n; i++) begin
            if (gaps && $urandom_range(0, 2) == 0) begin
                bus.s_valid = 1'b0;
                repeat ($urandom_range(1, 2)) @(posedge clk);
                #1;
            end
            d = rnd ? $urandom : d0 + 32'(i);
            bus.s_valid = 1'b1;
            bus.s_data  = d;
            bus.s_last  = use_last && (i == n - 1);
            t = 0;
            @(negedge clk);
            while (!bus.s_ready && t < 20) begin
                @(negedge clk);
                t++;
            end
            check("write_ready", 64'(bus.s_ready), 64'(1));
            @(posedge clk); #1;
            ref_mem[8'(int'(base) + i)] = d;
        end
        bus.s_valid = 1'b0;
        bus.s_last  = 1'b0;
        @(negedge clk);
        check("write_busy_drop", 64'(bus.busy), 64'(0));
        check("write_ready_drop", 64'(bus.s_ready), 64'(0));
        check("write_count", 64'(bus.wr_count), 64'(n));
    endtask

    task automatic do_read(input logic [7:0] base, input logic [8:0] len, input int mode);
        int    L, cyc, first, lastc, nb;
        beat_t e;
        L = (len == 9'd0) ? 256 : int'(len);
        for (int i = 0; i < L; i++) begin
            e.d = ref_mem[8'(int'(base) + i)];
            e.l = (i == L - 1);
            exp_q.push_back(e);
        end
        @(posedge clk); #1;
        bus.rd_base  = base;
        bus.rd_len   = len;
        bus.rd_start = 1'b1;
        bus.m_ready  = rdy_pat(mode, 0);
        @(posedge clk); #1;
        bus.rd_start = 1'b0;
        bus.m_ready  = rdy_pat(mode, 1);
        cyc = 0; first = -1; lastc = -1; nb = 0;
        forever begin
            @(negedge clk);
            cyc++;
            if (bus.m_valid && first < 0) first = cyc;
            if (bus.m_valid && bus.m_ready) begin
                nb++;
                if (bus.m_last) lastc = cyc;
            end
            if (lastc >= 0 && cyc == lastc + 1) begin
                check("read_busy_drop", 64'(bus.busy), 64'(0));
                break;
            end
            if (cyc > 4 * L + 50) begin
                check("read_finished", 64'(lastc >= 0), 64'(1));
                break;
            end
            @(posedge clk); #1;
            bus.m_ready = rdy_pat(mode, cyc + 1);
        end
        check("read_beat_count", 64'(nb), 64'(L));
        if (mode == 0) begin
            // rd_start is taken at the edge before cycle 1; first beat shows after two more edges.
            check("read_first_latency", 64'(first), 64'(3));
            check("read_back_to_back", 64'(lastc - first), 64'(L - 1));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] b;
        for (int i = 0; i < 256; i++) begin
            mem[i]     <= 32'h5A00_0000 + 32'(i);
            ref_mem[i]  = 32'h5A00_0000 + 32'(i);
        end
        rst = 1'b1;
        bus.wr_start = 1'b0; bus.wr_base = '0;
        bus.s_valid  = 1'b0; bus.s_data  = '0; bus.s_last = 1'b0;
        bus.rd_start = 1'b0; bus.rd_base = '0; bus.rd_len = '0;
        bus.m_ready  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_s_ready", 64'(bus.s_ready), 64'(0));
        check("rst_m_valid", 64'(bus.m_valid), 64'(0));
        check("rst_m_last", 64'(bus.m_last), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        check("rst_wr_count", 64'(bus.wr_count), 64'(0));
        check("rst_ram_we", 64'(bus.ram_we), 64'(0));
        check("rst_ram_addr", 64'(bus.ram_addr), 64'(0));
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed burst A0..A3 at 0x10, then replays with and without stalls.
        wr_begin(8'h10);
        wr_beats(8'h10, 4, 1'b1, 1'b0, 32'hA0, 1'b0);
        for (int i = 0; i < 4; i++) check("ram_after_write", 64'(mem[8'h10 + 8'(i)]), 64'(32'hA0 + i));
        do_read(8'h10, 9'd4, 0);
        do_read(8'h10, 9'd4, 1);

        // Address wrap on write and read.
        wr_begin(8'hFE);
        wr_beats(8'hFE, 4, 1'b1, 1'b0, 32'h0, 1'b1);
        check("wrap_ram_fe", 64'(mem[8'hFE]), 64'(ref_mem[8'hFE]));
        check("wrap_ram_ff", 64'(mem[8'hFF]), 64'(ref_mem[8'hFF]));
        check("wrap_ram_00", 64'(mem[8'h00]), 64'(ref_mem[8'h00]));
        check("wrap_ram_01", 64'(mem[8'h01]), 64'(ref_mem[8'h01]));
        do_read(8'hFE, 9'd4, 2);

        // rd_len=0 means a full 256-word window, wrapping from 0x80.
        do_read(8'h80, 9'd0, 0);

        // A write burst without s_last ends on its 256th beat.
        wr_begin(8'h80);
        wr_beats(8'h80, 256, 1'b0, 1'b0, 32'h0, 1'b1);
        do_read(8'h80, 9'd0, 2);

        // Simultaneous starts: write wins, the read is dropped; starts during WRITE are ignored.
        @(posedge clk); #1;
        bus.wr_base = 8'h40; bus.wr_start = 1'b1;
        bus.rd_base = 8'h00; bus.rd_len = 9'd4; bus.rd_start = 1'b1;
        bus.m_ready = 1'b1;
        @(posedge clk); #1;
        bus.wr_start = 1'b0; bus.rd_start = 1'b0;
        @(negedge clk);
        check("both_start_write", 64'(bus.s_ready), 64'(1));
        @(posedge clk); #1;
        bus.rd_start = 1'b1;
        @(posedge clk); #1;
        bus.rd_start = 1'b0;
        wr_beats(8'h40, 3, 1'b1, 1'b1, 32'h0, 1'b1);
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("both_start_no_read", 64'(bus.busy), 64'(0));

        // Random bursts followed by randomly stalled replays of nearby windows.
        for (int k = 0; k < 8; k++) begin
            b = 8'($urandom);
            wr_begin(b);
            wr_beats(b, $urandom_range(1, 12), 1'b1, 1'b1, 32'h0, 1'b1);
            do_read(b + 8'($urandom_range(0, 4)), 9'($urandom_range(1, 16)), 2);
        end

        // Reset during READ with the skid buffer full.
        @(posedge clk); #1;
        bus.rd_base = 8'h10; bus.rd_len = 9'd8; bus.rd_start = 1'b1; bus.m_ready = 1'b0;
        @(posedge clk); #1;
        bus.rd_start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("pre_reset_valid", 64'(bus.m_valid), 64'(1));
        check("pre_reset_busy", 64'(bus.busy), 64'(1));
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_m_valid", 64'(bus.m_valid), 64'(0));
        check("post_reset_busy", 64'(bus.busy), 64'(0));
        check("post_reset_ram_we", 64'(bus.ram_we), 64'(0));
        do_read(8'h10, 9'd4, 0);

        repeat (5) @(posedge clk);
        @(negedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
